simple_bit_unpack: RTL and testbench



---
 rtl/simple_bit_unpack.sv | 47 ++++
 tb/tb_simple_bit_unpack.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/simple_bit_unpack.sv
// SimpleBitUnpack register: splits a packed 256-coefficient stream into BL-bit unsigned fields.
// Optional build macro SIMPLE_BIT_UNPACK_CLAMP_EN saturates fields above b to b.
module simple_bit_unpack #(
  parameter int unsigned b = 1023,
  localparam int unsigned BL = $clog2(b + 1),
  localparam int unsigned VW = 256 * BL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VW-1:0]         v,
  output logic [255:0][BL-1:0]  w
);

  logic [255:0][BL-1:0] w_d;
  logic [255:0][BL-1:0] w_q;

  function automatic logic [BL-1:0] sat_field(input logic [BL-1:0] x);
`ifdef SIMPLE_BIT_UNPACK_CLAMP_EN
    if (x > BL'(b)) begin
      return BL'(b);
    end
    return x;
`else
    return x;
`endif
  endfunction

  // Field i occupies stream bits [i*BL +: BL], LSB first.
  always_comb begin
    w_d = '0;
    for (int i = 0; i < 256; i++) begin
      w_d[i] = sat_field(v[i*BL +: BL]);
    end
  end

  // Output register stage: reloads every edge, async clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q <= '0;
    end else begin
      w_q <= w_d;
    end
  end

  assign w = w_q;

endmodule

// File: tb/tb_simple_bit_unpack.sv
// Directed bench for simple_bit_unpack: b=1023 main instance plus a b=5 instance for clamping.
module tb_simple_bit_unpack;

  logic                  clk;
  logic                  reset;
  logic [2559:0]         v;
  logic [255:0][9:0]     w;
  logic [767:0]          v2;
  logic [255:0][2:0]     w2;

  int checks;
  int errors;

  simple_bit_unpack #(.b(1023)) dut (
    .clk  (clk),
    .reset(reset),
    .v    (v),
    .w    (w)
  );

  simple_bit_unpack #(.b(5)) dut5 (
    .clk  (clk),
    .reset(reset),
    .v    (v2),
    .w    (w2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_diff(input logic [255:0][9:0] a, input logic [255:0][9:0] e);
    for (int i = 0; i < 256; i++) begin
      if (a[i] !== e[i]) return i;
    end
    return 0;
  endfunction

  task automatic test_reset();
    logic [255:0][9:0] exp;
    int k;
    v  = '1;
    v2 = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    exp = '0;
    checks++;
    if (w !== exp) begin
      errors++; k = first_diff(w, exp);
      $display("FAIL reset_async: w[%0d]=%0d expected %0d", k, w[k], exp[k]);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (w !== exp) begin
      errors++; k = first_diff(w, exp);
      $display("FAIL reset_hold: w[%0d]=%0d expected %0d", k, w[k], exp[k]);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (w !== exp) begin
      errors++; k = first_diff(w, exp);
      $display("FAIL reset_release_no_edge: w[%0d]=%0d expected %0d", k, w[k], exp[k]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) exp[i] = 10'd1023;
    checks++;
    if (w !== exp) begin
      errors++; k = first_diff(w, exp);
      $display("FAIL reset_release_load: w[%0d]=%0d expected %0d", k, w[k], exp[k]);
    end
  endtask

  task automatic test_index();
    logic [255:0][9:0] exp;
    logic [2559:0] tmp;
    int k;
    @(negedge clk);
    tmp = '0;
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 10; j++) tmp[i*10 + j] = ((i >> j) & 1) != 0;
      exp[i] = 10'(i);
    end
    v = tmp;
    @(posedge clk);
    #1;
    checks++;
    if (w !== exp) begin
      errors++; k = first_diff(w, exp);
      $display("FAIL index_all: w[%0d]=%0d expected %0d", k, w[k], exp[k]);
    end
    checks++;
    if (w[0] !== 10'd0) begin
      errors++; $display("FAIL index_w0: got %0d expected 0", w[0]);
    end
    checks++;
    if (w[1] !== 10'd1) begin
      errors++; $display("FAIL index_w1: got %0d expected 1", w[1]);
    end
    checks++;
    if (w[255] !== 10'd255) begin
      errors++; $display("FAIL index_w255: got %0d expected 255", w[255]);
    end
  endtask

  task automatic test_boundary();
    logic [255:0][9:0] exp;
    int k;
    @(negedge clk);
    v = '0;
    v[0] = 1'b1;
    @(posedge clk);
    #1;
    exp = '0;
    exp[0] = 10'd1;
    checks++;
    if (w !== exp) begin
      errors++; k = first_diff(w, exp);
      $display("FAIL boundary_bit0: w[%0d]=%0d expected %0d", k, w[k], exp[k]);
    end
    @(negedge clk);
    v = '0;
    v[2559] = 1'b1;
    @(posedge clk);
    #1;
    exp = '0;
    exp[255] = 10'd512;
    checks++;
    if (w !== exp) begin
      errors++; k = first_diff(w, exp);
      $display("FAIL boundary_bit2559: w[%0d]=%0d expected %0d", k, w[k], exp[k]);
    end
  endtask

  task automatic test_latency();
    logic [255:0][9:0] exp;
    int k;
    @(negedge clk);
    v = '0;
    @(posedge clk);
    #1;
    v = '1;
    #2;
    exp = '0;
    checks++;
    if (w !== exp) begin
      errors++; k = first_diff(w, exp);
      $display("FAIL latency_no_comb_path: w[%0d]=%0d expected %0d", k, w[k], exp[k]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 256; i++) exp[i] = 10'd1023;
    checks++;
    if (w !== exp) begin
      errors++; k = first_diff(w, exp);
      $display("FAIL latency_next_edge: w[%0d]=%0d expected %0d", k, w[k], exp[k]);
    end
  endtask

  task automatic test_mid_reset();
    logic [255:0][9:0] exp;
    int k;
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    exp = '0;
    checks++;
    if (w !== exp) begin
      errors++; k = first_diff(w, exp);
      $display("FAIL midreset_immediate: w[%0d]=%0d expected %0d", k, w[k], exp[k]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (w !== exp) begin
      errors++; k = first_diff(w, exp);
      $display("FAIL midreset_hold: w[%0d]=%0d expected %0d", k, w[k], exp[k]);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_clamp();
    logic [2:0] exp0;
    logic [2:0] exp2;
`ifdef SIMPLE_BIT_UNPACK_CLAMP_EN
    exp0 = 3'd5;
    exp2 = 3'd5;
`else
    exp0 = 3'd7;
    exp2 = 3'd6;
`endif
    @(negedge clk);
    v2 = '0;
    v2[2:0] = 3'd7;
    v2[5:3] = 3'd5;
    v2[8:6] = 3'd6;
    v2[767:765] = 3'd4;
    @(posedge clk);
    #1;
    checks++;
    if (w2[0] !== exp0) begin
      errors++; $display("FAIL clamp_field0: got %0d expected %0d", w2[0], exp0);
    end
    checks++;
    if (w2[1] !== 3'd5) begin
      errors++; $display("FAIL clamp_field1: got %0d expected 5", w2[1]);
    end
    checks++;
    if (w2[2] !== exp2) begin
      errors++; $display("FAIL clamp_field2: got %0d expected %0d", w2[2], exp2);
    end
    checks++;
    if (w2[255] !== 3'd4) begin
      errors++; $display("FAIL clamp_field255: got %0d expected 4", w2[255]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_index();
    test_boundary();
    test_latency();
    test_mid_reset();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
